// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared state encoding, command-byte layout and decode helper for the SPI register sequencer
package spi_seq_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ_FETCH,
    ST_READ_SEND,
    ST_IGNORE
  } state_t;
  localparam int CMD_WR_BIT = 7;
  localparam logic [7:0] TX_IDLE_BYTE = 8'h00;
  typedef struct packed {
    logic is_write;
    logic [6:0] addr;
    logic addr_valid;
  } cmd_t;
  function automatic cmd_t decode_cmd(input logic [7:0] cmd, input int addr_w);
    logic [6:0] mask;
    mask = 7'((8'd1 << addr_w) - 8'd1);
    return '{cmd[CMD_WR_BIT], cmd[6:0] & mask, (cmd[6:0] & ~mask) == 7'd0};
  endfunction
endpackage

// File: rtl/spi_seq_cmd_decode.sv
// spi_seq_cmd_decode: combinational split of a command byte into direction, start address and validity
module spi_seq_cmd_decode
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic [7:0]        cmd,
  output logic              is_write,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid
);
  cmd_t f;
  assign f = decode_cmd(cmd, ADDR_W);
  assign is_write = f.is_write;
  assign addr = ADDR_W'(f.addr);
  assign addr_valid = f.addr_valid;
endmodule

// File: rtl/spi_reg_sequencer.sv
// spi_reg_sequencer: SPI byte stream to register-bank transaction controller; define SPI_SEQ_AUTOINC_EN for burst address auto-increment
module spi_reg_sequencer
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_active,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              tx_load,
  output logic [DATA_W-1:0] tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy,
  output logic              err
);
`ifdef SPI_SEQ_AUTOINC_EN
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] STEP = '0;
`endif
  state_t state;
  logic cs_q;
  logic [ADDR_W-1:0] addr;
  logic dec_write;
  logic dec_valid;
  logic [ADDR_W-1:0] dec_addr;
  spi_seq_cmd_decode #(.ADDR_W(ADDR_W)) u_dec (
    .cmd(rx_data),
    .is_write(dec_write),
    .addr(dec_addr),
    .addr_valid(dec_valid)
  );
  assign reg_addr = addr;
  assign reg_re = state == ST_READ_FETCH;
  assign busy = state != ST_IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cs_q <= 1'b0;
      addr <= '0;
      tx_data <= TX_IDLE_BYTE;
      tx_load <= 1'b0;
      reg_wdata <= '0;
      reg_we <= 1'b0;
      err <= 1'b0;
    end else begin
      cs_q <= cs_active;
      tx_load <= 1'b0;
      reg_we <= 1'b0;
      if (state != ST_IDLE && !cs_active)
        state <= ST_IDLE;
      else
        case (state)
          ST_IDLE: if (cs_active && !cs_q) begin
            state <= ST_CMD;
            err <= 1'b0;
            tx_data <= TX_IDLE_BYTE;
          end
          ST_CMD: if (rx_valid) begin
            state <= !dec_valid ? ST_IGNORE : dec_write ? ST_WRITE : ST_READ_FETCH;
            err <= !dec_valid;
            addr <= dec_valid ? dec_addr : addr;
          end
          ST_WRITE: begin
            reg_we <= rx_valid;
            reg_wdata <= rx_valid ? rx_data : reg_wdata;
            // step only after the strobe cycle so reg_addr is stable while reg_we is high
            addr <= reg_we ? addr + STEP : addr;
          end
          ST_READ_FETCH: begin
            tx_data <= reg_rdata;
            tx_load <= 1'b1;
            state <= ST_READ_SEND;
          end
          ST_READ_SEND: if (rx_valid) begin
            addr <= addr + STEP;
            state <= ST_READ_FETCH;
          end
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_spi_reg_sequencer.sv
// tb_spi_reg_sequencer: table vectors, hand corner cases and random transactions checked against a transaction-level model
module tb_spi_reg_sequencer;
`ifdef SPI_SEQ_AUTOINC_EN
  localparam int STEP = 1;
`else
  localparam int STEP = 0;
`endif
  logic clk = 0, rst = 1, cs_active = 0, rx_valid = 0;
  logic [7:0] rx_data = 0;
  logic tx_load, reg_we, reg_re, busy, err;
  logic [7:0] tx_data, reg_wdata, reg_rdata;
  logic [2:0] reg_addr;
  logic [7:0] bank [8] = '{8'hF0, 8'hF1, 8'hF2, 8'h11, 8'h22, 8'h33, 8'hF6, 8'hF7};
  logic [7:0] mdl [8] = '{8'hF0, 8'hF1, 8'hF2, 8'h11, 8'h22, 8'h33, 8'hF6, 8'hF7};
  spi_reg_sequencer dut (
    .clk(clk), .rst(rst), .cs_active(cs_active), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_load(tx_load), .tx_data(tx_data), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  assign reg_rdata = bank[reg_addr];
  always @(posedge clk) if (reg_we) bank[reg_addr] = reg_wdata;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct { logic [2:0] a; logic [7:0] d; } wr_t;
  typedef struct {
    logic [7:0] cmd; logic [3:0][7:0] b; int nb;
    logic e_err; int e_we; logic [2:0] e_waddr; logic [7:0] e_wdata;
    int e_tx; logic [7:0] e_tx_first; logic [7:0] e_tx_last;
  } vec_t;
  wr_t wr_q[$], ewr_q[$], mon_w, ew;
  logic [7:0] tx_q[$], etx_q[$];
  logic exp_err;
  vec_t tv[6];
  int tests = 0, fails = 0, last_rx = -100, we_n = 0, tx_n = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rx_valid && cs_active) last_rx = cyc;
    if (reg_we) begin
      mon_w.a = reg_addr;
      mon_w.d = reg_wdata;
      wr_q.push_back(mon_w);
      we_n++;
      chk("we_latency", cyc - last_rx, 1);
    end
    if (tx_load) begin
      tx_q.push_back(tx_data);
      tx_n++;
      chk("tx_latency", cyc - last_rx, 2);
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1;
    tick();
    rx_valid = 0;
    tick(9);
  endtask
  task automatic cs_on();
    cs_active = 1;
    tick(2);
  endtask
  task automatic cs_off();
    tick(3);
    cs_active = 0;
    tick(2);
  endtask
  task automatic run_txn(input logic [7:0] cmd, input logic [3:0][7:0] b, input int nb);
    wr_q.delete();
    tx_q.delete();
    cs_on();
    send(cmd);
    for (int i = 0; i < nb; i++) send(b[i]);
    cs_off();
  endtask
  task automatic model(input logic [7:0] cmd, input logic [3:0][7:0] b, input int nb);
    int a;
    a = cmd % 8;
    ewr_q.delete();
    etx_q.delete();
    exp_err = (cmd & 8'h78) != 0;
    if (exp_err) return;
    if (cmd >= 8'h80)
      for (int i = 0; i < nb; i++) begin
        ew.a = 3'(a);
        ew.d = b[i];
        ewr_q.push_back(ew);
        mdl[a] = b[i];
        a = (a + STEP) % 8;
      end
    else begin
      etx_q.push_back(mdl[a]);
      for (int i = 0; i < nb; i++) begin
        a = (a + STEP) % 8;
        etx_q.push_back(mdl[a]);
      end
    end
  endtask
  initial begin
    tv[0] = '{8'h82, 32'h5A, 1, 1'b0, 1, 3'd2, 8'h5A, 0, 8'h00, 8'h00};
    tv[1] = '{8'h03, 32'h0, 2, 1'b0, 0, 3'd0, 8'h00, 3, 8'h11, STEP != 0 ? 8'h33 : 8'h11};
    tv[2] = '{8'h87, 32'hA2A1, 2, 1'b0, 2, STEP != 0 ? 3'd0 : 3'd7, 8'hA2, 0, 8'h00, 8'h00};
    tv[3] = '{8'h07, 32'h0, 1, 1'b0, 0, 3'd0, 8'h00, 2, STEP != 0 ? 8'hA1 : 8'hA2, 8'hA2};
    tv[4] = '{8'h48, 32'h3412, 2, 1'b1, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00};
    tv[5] = '{8'hC8, 32'h77, 1, 1'b1, 0, 3'd0, 8'h00, 0, 8'h00, 8'h00};
    tick(3);
    chk("reset_outs", {tx_load, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, err}, 0);
    rst = 0;
    tick(2);
    chk("idle_outs", {tx_load, reg_we, reg_re, busy, err}, 0);
    for (int i = 0; i < 6; i++) begin
      model(tv[i].cmd, tv[i].b, tv[i].nb);
      run_txn(tv[i].cmd, tv[i].b, tv[i].nb);
      chk($sformatf("v%0d_err", i), err, tv[i].e_err);
      chk($sformatf("v%0d_we_count", i), wr_q.size(), tv[i].e_we);
      chk($sformatf("v%0d_tx_count", i), tx_q.size(), tv[i].e_tx);
      if (tv[i].e_we > 0 && wr_q.size() > 0) begin
        chk($sformatf("v%0d_waddr", i), wr_q[$].a, tv[i].e_waddr);
        chk($sformatf("v%0d_wdata", i), wr_q[$].d, tv[i].e_wdata);
      end
      if (tv[i].e_tx > 0 && tx_q.size() > 0) begin
        chk($sformatf("v%0d_tx_first", i), tx_q[0], tv[i].e_tx_first);
        chk($sformatf("v%0d_tx_last", i), tx_q[$], tv[i].e_tx_last);
      end
    end
    chk("bank7", bank[7], STEP != 0 ? 8'hA1 : 8'hA2);
    chk("bank0", bank[0], STEP != 0 ? 8'hA2 : 8'hF0);
    cs_on();
    chk("err_clear", err, 0);
    chk("busy_cmd", busy, 1);
    cs_off();
    begin
      int we0;
      we0 = we_n;
      cs_on();
      send(8'h82);
      rx_data = 8'h5A;
      rx_valid = 1;
      cs_active = 0;
      tick();
      rx_valid = 0;
      chk("abort_busy", busy, 0);
      tick(3);
      chk("abort_no_we", we_n - we0, 0);
    end
    begin
      int tx0;
      tx0 = tx_n;
      cs_on();
      rx_data = 8'h03;
      rx_valid = 1;
      tick();
      rx_valid = 0;
      chk("fetch_re", reg_re, 1);
      rst = 1;
      tick();
      chk("rst_mid_outs", {tx_load, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy, err}, 0);
      rst = 0;
      cs_active = 0;
      tick(3);
      chk("rst_mid_no_tx", tx_n - tx0, 0);
      chk("rst_mid_idle", busy, 0);
    end
    for (int t = 0; t < 40; t++) begin
      logic [7:0] cmd;
      logic [3:0][7:0] b;
      int nb;
      cmd = {1'($urandom), ($urandom % 5 == 0) ? 4'($urandom_range(1, 15)) : 4'd0, 3'($urandom)};
      b = $urandom;
      nb = $urandom_range(0, 4);
      model(cmd, b, nb);
      run_txn(cmd, b, nb);
      chk($sformatf("r%0d_err", t), err, exp_err);
      chk($sformatf("r%0d_we_count", t), wr_q.size(), ewr_q.size());
      chk($sformatf("r%0d_tx_count", t), tx_q.size(), etx_q.size());
      for (int k = 0; k < ewr_q.size() && k < wr_q.size(); k++) begin
        chk($sformatf("r%0d_waddr%0d", t, k), wr_q[k].a, ewr_q[k].a);
        chk($sformatf("r%0d_wdata%0d", t, k), wr_q[k].d, ewr_q[k].d);
      end
      for (int k = 0; k < etx_q.size() && k < tx_q.size(); k++)
        chk($sformatf("r%0d_tx%0d", t, k), tx_q[k], etx_q[k]);
      chk($sformatf("r%0d_idle", t), busy, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
